// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch stage sitting right after the PC register.
// Issues in-order imem requests at fetch_pc, keeps a DEPTH-slot queue of
// {pc, instr, filled} entries, and feeds the IF/ID registers.
// A flush discards all queued and in-flight fetches; responses for fetches
// that were already sent get dropped through kill_cnt.
// Optional build macro: FETCH_PERF_EN adds the perf_fetched / perf_killed
// counter outputs.
module if_fetch_queue #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pc_hold,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        flush,
    input  logic        stall,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_instr,
    output logic        ID_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_killed
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Kill counter has headroom for several back-to-back flushes against
    // a memory that keeps more requests in flight than the queue holds.
    localparam int KW = PW + 4;

    // Slot storage
    logic [31:0]      slot_pc_reg    [DEPTH];
    logic [31:0]      slot_instr_reg [DEPTH];
    logic [DEPTH-1:0] filled_reg;

    // Queue bookkeeping
    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [PW-1:0] fill_ptr_reg;
    logic [CW-1:0] alloc_cnt_reg;
    logic [CW-1:0] pend_cnt_reg;
    logic [KW-1:0] kill_cnt_reg;

    // One-hot slot selects
    logic [DEPTH-1:0] head_sel;
    logic [DEPTH-1:0] tail_sel;
    logic [DEPTH-1:0] fill_sel;

    logic accept;
    logic rsp_kill;
    logic rsp_live;
    logic head_filled;
    logic bypass;
    logic pop;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
        assign head_sel[gi] = (head_reg == PW'(gi));
        assign tail_sel[gi] = (tail_reg == PW'(gi));
        assign fill_sel[gi] = (fill_ptr_reg == PW'(gi));
    end

    // A request slot is granted only against credit that exists at the start
    // of the cycle; a same-cycle pop frees its slot for the next cycle.
    assign imem_req_valid = !flush && (alloc_cnt_reg < CW'(DEPTH));
    assign imem_addr      = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign pc_hold        = !accept;

    assign rsp_kill = imem_rsp_valid && (kill_cnt_reg != '0);
    assign rsp_live = imem_rsp_valid && (kill_cnt_reg == '0);

    // Filled slots always form a contiguous run starting at head, so an
    // unfilled head is necessarily the slot the next live response fills.
    assign head_filled = (alloc_cnt_reg != '0) && filled_reg[head_reg];
    assign bypass      = (alloc_cnt_reg != '0) && !filled_reg[head_reg]
                         && rsp_live && (fill_ptr_reg == head_reg);
    assign pop         = !flush && !stall && (head_filled || bypass);

    // Slot contents: allocate at tail, fill at fill_ptr, release at head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_pc_reg[i]    <= '0;
                slot_instr_reg[i] <= NOP;
            end
            filled_reg <= '0;
        end else if (flush) begin
            filled_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && tail_sel[i]) begin
                    slot_pc_reg[i] <= fetch_pc;
                    filled_reg[i]  <= 1'b0;
                end
                if (rsp_live && fill_sel[i]) begin
                    slot_instr_reg[i] <= imem_rsp_data;
                    filled_reg[i]     <= 1'b1;
                end
                if (pop && head_sel[i]) begin
                    filled_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Pointers, occupancy, in-flight and kill accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            fill_ptr_reg  <= '0;
            alloc_cnt_reg <= '0;
            pend_cnt_reg  <= '0;
            kill_cnt_reg  <= '0;
        end else if (flush) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            fill_ptr_reg  <= '0;
            alloc_cnt_reg <= '0;
            pend_cnt_reg  <= '0;
            // Every still-unfilled slot has a response on its way that must
            // be discarded; a response landing now (live or already doomed)
            // consumes one of those debts immediately.
            kill_cnt_reg  <= kill_cnt_reg + KW'(pend_cnt_reg) - KW'(imem_rsp_valid);
        end else begin
            if (accept) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (rsp_live) begin
                fill_ptr_reg <= fill_ptr_reg + PW'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PW'(1);
            end
            alloc_cnt_reg <= alloc_cnt_reg + CW'(accept) - CW'(pop);
            pend_cnt_reg  <= pend_cnt_reg + CW'(accept) - CW'(rsp_live);
            if (rsp_kill) begin
                kill_cnt_reg <= kill_cnt_reg - KW'(1);
            end
        end
    end

    // IF/ID pipeline registers: flush beats stall beats advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ID_pc    <= '0;
            ID_instr <= NOP;
            ID_valid <= 1'b0;
        end else if (flush) begin
            ID_instr <= NOP;
            ID_valid <= 1'b0;
        end else if (stall) begin
            // decode is stalled: hold pc, instr and valid as they are
        end else if (head_filled || bypass) begin
            ID_pc    <= slot_pc_reg[head_reg];
            ID_instr <= head_filled ? slot_instr_reg[head_reg] : imem_rsp_data;
            ID_valid <= 1'b1;
        end else begin
            ID_instr <= NOP;
            ID_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_killed_reg;

    // Free-running event counters, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_reg <= '0;
            perf_killed_reg  <= '0;
        end else begin
            if (accept) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (rsp_kill) begin
                perf_killed_reg <= perf_killed_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_killed  = perf_killed_reg;
`endif

    // A live response with nothing waiting for it means memory broke the
    // one-response-per-accepted-request contract.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(rsp_live && (pend_cnt_reg == '0)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed bench for if_fetch_queue (DEPTH=2).
// Inputs change 1 time unit after each rising edge; outputs are checked
// 1 unit later, well before the next edge.
module tb_if_fetch_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pc_hold;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        flush;
    logic        stall;
    logic [31:0] ID_pc;
    logic [31:0] ID_instr;
    logic        ID_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_killed;
`endif

    int total = 0;
    int bad   = 0;

    if_fetch_queue #(.DEPTH(2), .NOP(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_pc       (fetch_pc),
        .pc_hold        (pc_hold),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .flush          (flush),
        .stall          (stall),
        .ID_pc          (ID_pc),
        .ID_instr       (ID_instr),
        .ID_valid       (ID_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_killed    (perf_killed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, then let combinational outputs settle
    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic fl, input logic st, input logic [31:0] pc);
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        flush          = fl;
        stall          = st;
        fetch_pc       = pc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_id(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] ins);
        chk({tag, ".valid"}, ID_valid, v);
        chk({tag, ".pc"}, ID_pc, pc);
        chk({tag, ".instr"}, ID_instr, ins);
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        flush = 1'b0;
        stall = 1'b0;
        fetch_pc = '0;
        #1;
        chk_id("reset", 1'b0, 32'h0, NOP);
        chk("reset.req_valid", imem_req_valid, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- streaming with 1-cycle memory ----
        drive(1, 0, 0, 0, 0, 32'h0);
        chk("s1.a.pc_hold", pc_hold, 1'b0);
        chk("s1.a.addr", imem_addr, 32'h0);
        chk("s1.a.id_valid", ID_valid, 1'b0);
        tick();
        drive(1, 1, 32'h11110000, 0, 0, 32'h4);
        chk("s1.b.pc_hold", pc_hold, 1'b0);
        chk("s1.b.id_valid", ID_valid, 1'b0);
        tick();
        drive(1, 1, 32'h11110004, 0, 0, 32'h8);
        chk("s1.c.pc_hold", pc_hold, 1'b0);
        chk_id("s1.c", 1'b1, 32'h0, 32'h11110000);
        tick();
        drive(0, 1, 32'h11110008, 0, 0, 32'hC);
        chk_id("s1.d", 1'b1, 32'h4, 32'h11110004);
        tick();
        drive(0, 0, 0, 0, 0, 32'hC);
        chk_id("s1.e", 1'b1, 32'h8, 32'h11110008);
        tick();
        drive(0, 0, 0, 0, 0, 32'h10);
        chk_id("s1.f", 1'b0, 32'h8, NOP);

        // ---- memory not ready for 3 cycles ----
        for (int i = 0; i < 3; i++) begin
            chk("s2.wait.pc_hold", pc_hold, 1'b1);
            chk("s2.wait.req_valid", imem_req_valid, 1'b1);
            tick();
            drive(0, 0, 0, 0, 0, 32'h10);
        end
        drive(1, 0, 0, 0, 0, 32'h10);
        chk("s2.go.pc_hold", pc_hold, 1'b0);
        tick();
        drive(0, 1, 32'h22220010, 0, 0, 32'h14);
        chk("s2.after.pc_hold", pc_hold, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 32'h14);
        chk_id("s2.out", 1'b1, 32'h10, 32'h22220010);
        tick();
        drive(0, 0, 0, 0, 0, 32'h14);
        chk("s2.once", ID_valid, 1'b0);

        // ---- decode stall with memory streaming ----
        drive(1, 0, 0, 0, 0, 32'h20);
        tick();
        drive(1, 1, 32'h33330020, 0, 0, 32'h24);
        tick();
        drive(1, 1, 32'h33330024, 0, 1, 32'h28);
        chk_id("s3.enter", 1'b1, 32'h20, 32'h33330020);
        tick();
        drive(1, 1, 32'h33330028, 0, 1, 32'h2C);
        chk("s3.full.req_valid", imem_req_valid, 1'b0);
        chk("s3.full.pc_hold", pc_hold, 1'b1);
        chk("s3.full.alloc", dut.alloc_cnt_reg, 32'd2);
        chk_id("s3.hold1", 1'b1, 32'h20, 32'h33330020);
        tick();
        drive(1, 0, 0, 0, 1, 32'h2C);
        chk_id("s3.hold2", 1'b1, 32'h20, 32'h33330020);
        tick();
        drive(1, 0, 0, 0, 1, 32'h2C);
        chk_id("s3.hold3", 1'b1, 32'h20, 32'h33330020);
        chk("s3.hold3.req_valid", imem_req_valid, 1'b0);
        tick();
        drive(1, 0, 0, 0, 0, 32'h2C);
        chk("s3.release.req_valid", imem_req_valid, 1'b0);
        chk_id("s3.release", 1'b1, 32'h20, 32'h33330020);
        tick();
        drive(0, 0, 0, 0, 0, 32'h2C);
        chk_id("s3.drain1", 1'b1, 32'h24, 32'h33330024);
        tick();
        drive(0, 0, 0, 0, 0, 32'h2C);
        chk_id("s3.drain2", 1'b1, 32'h28, 32'h33330028);
        tick();
        drive(0, 0, 0, 0, 0, 32'h2C);
        chk("s3.empty", ID_valid, 1'b0);

        // ---- flush with two requests in flight ----
        drive(1, 0, 0, 0, 0, 32'h30);
        tick();
        drive(1, 0, 0, 0, 0, 32'h34);
        tick();
        drive(1, 0, 0, 1, 0, 32'h38);
        chk("s4.flush.req_valid", imem_req_valid, 1'b0);
        chk("s4.flush.pc_hold", pc_hold, 1'b1);
        tick();
        drive(1, 1, 32'hDEAD0030, 0, 0, 32'h100);
        chk("s4.kill2", dut.kill_cnt_reg, 32'd2);
        chk("s4.after.req_valid", imem_req_valid, 1'b1);
        chk_id("s4.k2", 1'b0, 32'h28, NOP);
        tick();
        drive(0, 1, 32'hDEAD0034, 0, 0, 32'h104);
        chk("s4.kill1", dut.kill_cnt_reg, 32'd1);
        chk_id("s4.k1", 1'b0, 32'h28, NOP);
        tick();
        drive(0, 1, 32'h44440100, 0, 0, 32'h104);
        chk("s4.kill0", dut.kill_cnt_reg, 32'd0);
        chk_id("s4.k0", 1'b0, 32'h28, NOP);
        tick();
        drive(0, 0, 0, 0, 0, 32'h104);
        chk_id("s4.target", 1'b1, 32'h100, 32'h44440100);
        tick();

        // ---- flush coincident with live response under stall ----
        drive(1, 0, 0, 0, 0, 32'h40);
        tick();
        drive(1, 1, 32'h55550040, 0, 0, 32'h44);
        tick();
        drive(1, 0, 0, 0, 1, 32'h48);
        tick();
        drive(1, 1, 32'h55550044, 1, 1, 32'h4C);
        chk("s5.flush.req_valid", imem_req_valid, 1'b0);
        chk_id("s5.pre", 1'b1, 32'h40, 32'h55550040);
        tick();
        drive(0, 1, 32'hDEAD0048, 0, 0, 32'h200);
        chk("s5.kill1", dut.kill_cnt_reg, 32'd1);
        chk("s5.post.valid", ID_valid, 1'b0);
        chk("s5.post.instr", ID_instr, NOP);
        tick();
        drive(0, 0, 0, 0, 0, 32'h200);
        chk("s5.kill0", dut.kill_cnt_reg, 32'd0);
        chk("s5.post2.valid", ID_valid, 1'b0);

        // ---- fetch counting, one kill, then async reset mid-run ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 0, 0, 0, 0, 32'h200);
        tick();
        drive(1, 1, 32'h66660200, 0, 0, 32'h204);
        tick();
        drive(1, 1, 32'h66660204, 0, 0, 32'h208);
        tick();
        drive(1, 1, 32'h66660208, 0, 0, 32'h20C);
        tick();
        drive(1, 1, 32'h6666020C, 0, 0, 32'h210);
        chk_id("s6.stream", 1'b1, 32'h208, 32'h66660208);
        tick();
        drive(1, 0, 0, 1, 0, 32'h214);
        tick();
        drive(0, 1, 32'hDEAD0210, 0, 0, 32'h300);
        tick();
        drive(1, 0, 0, 0, 0, 32'h300);
        chk("s6.killed_drained", dut.kill_cnt_reg, 32'd0);
`ifdef FETCH_PERF_EN
        chk("s6.perf_fetched", perf_fetched, 32'd5);
        chk("s6.perf_killed", perf_killed, 32'd1);
`endif
        tick();
        drive(0, 1, 32'h77770300, 0, 0, 32'h304);
        tick();
        drive(0, 0, 0, 0, 0, 32'h304);
        chk_id("s6.pre_rst", 1'b1, 32'h300, 32'h77770300);
`ifdef FETCH_PERF_EN
        chk("s6.pre_rst.perf_fetched", perf_fetched, 32'd6);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk_id("s6.async_rst", 1'b0, 32'h0, NOP);
`ifdef FETCH_PERF_EN
        chk("s6.rst.perf_fetched", perf_fetched, 32'd0);
        chk("s6.rst.perf_killed", perf_killed, 32'd0);
`endif
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0);
        chk("s6.after_rst.alloc", dut.alloc_cnt_reg, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Fetch stage directly downstream of the PC register. It issues instruction-memory requests at the current fetch PC with a valid/ready handshake and tracks in-flight requests in order. It buffers returned instructions with their PCs in a DEPTH-slot queue and drives the IF/ID pipeline registers (ID_pc, ID_instr, ID_valid) consumed by decode. It holds the PC while it cannot accept a fetch, and kills wrong-path fetches on a redirect flush.

Parameters:
DEPTH, 2, queue slots and maximum outstanding requests; power of two, >=2
NOP, 32'h00000013, instruction driven on ID_instr when ID_valid=0

Ports:
clk  in  1  clock
rst  in  1  reset
fetch_pc  in  32  current PC from the PC register
pc_hold  out  1  1 = PC must not advance this cycle
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  request address (= fetch_pc)
imem_rsp_valid  in  1  in-order response valid, one per accepted request
imem_rsp_data  in  32  returned instruction
flush  in  1  taken branch/jump/JALR redirect
stall  in  1  decode stall; hold IF/ID registers
ID_pc  out  32  PC of instruction in ID
ID_instr  out  32  instruction in ID
ID_valid  out  1  ID_instr is a real instruction

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. Queue empty, outstanding=0, kill_cnt=0, ID_valid=0, ID_pc=0, ID_instr=NOP. Reset mid-transaction drops all in-flight state; responses arriving after reset release are ignored only if kill_cnt covers them (they do not: memory is reset by the same rst).
- Slot = {pc, instr, filled}. alloc_cnt = slots allocated (filled or waiting), 0..DEPTH.
- imem_req_valid = !flush && alloc_cnt < DEPTH. Credit from a same-cycle pop is not reused that cycle.
- Accept (req_valid && req_ready): allocate tail slot with pc=fetch_pc, filled=0; tail++ mod DEPTH.
- pc_hold = !(imem_req_valid && imem_req_ready). PC advances exactly once per accepted request.
- Response: if kill_cnt>0, discard and kill_cnt--. Otherwise write instr to the oldest unfilled slot and set filled.
- IF/ID update per edge, in priority order:
  - flush: ID_valid<=0, ID_instr<=NOP.
  - stall: hold all three.
  - head filled, or head receiving a live response this cycle (bypass): load ID_pc/ID_instr, ID_valid<=1, pop head.
  - otherwise: ID_valid<=0, ID_instr<=NOP, ID_pc held.
- Minimum latency: request accepted in cycle T, response in T+k (k>=1), ID_valid=1 in cycle T+k+1.
- Flush cycle:
  - No request issued and no pop.
  - All slots cleared, alloc_cnt<=0.
  - kill_cnt <= kill_cnt + live unfilled slots, minus 1 if a live response arrives that same cycle (that response is dropped).
- Stall with full queue: requests stop (alloc_cnt=DEPTH), pc_hold=1, responses still fill slots.
- Pointers wrap mod DEPTH. alloc_cnt never exceeds DEPTH. A response while kill_cnt=0 and no unfilled slot is a protocol error (assertion).

Optional Feature:
FETCH_PERF_EN: when defined, adds outputs perf_fetched[31:0] (accepted requests) and perf_killed[31:0] (responses discarded via kill_cnt). Both reset to 0 and wrap at 2^32. When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Ready=1, 1-cycle memory, fetch_pc 0,4,8 -> ID_valid rises 2 cycles after first request; ID_pc 0,4,8 on consecutive cycles; pc_hold=0 throughout.
- imem_req_ready=0 for 3 cycles at pc=0x10 -> pc_hold=1 those cycles; single request at 0x10 once ready=1; ID_pc=0x10 exactly once.
- stall=1 for 4 cycles with memory streaming -> ID regs frozen; alloc_cnt reaches 2; req_valid=0, pc_hold=1; release -> remaining instrs in order, none lost or duplicated.
- 2 requests outstanding, flush; the next 2 responses are garbage -> both dropped (kill_cnt 2->0); ID_instr=NOP and ID_valid=0 until the first post-flush response.
- flush coincident with live response and stall=1 -> response dropped, ID_valid<=0, kill_cnt counts only the remaining unfilled slots.
- FETCH_PERF_EN defined, 5 fetches with 1 killed -> perf_fetched=5, perf_killed=1; reset asserted mid-run -> both counters 0 and ID_instr=NOP immediately.
